e203_rr_arb16: RTL



---
 rtl/e203_rr_arb16.sv | 134 +++++++++++++
 1 files changed

// File: rtl/e203_rr_arb16.sv
// 16-requester round-robin arbiter with capped burst lock.
// Registered one-hot grant and binary index; back-to-back re-arbitration on handshake.
module e203_rr_arb16 #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req_valid,
    input  logic [15:0] req_lock,
    output logic [15:0] req_ready,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [15:0] o_grant_oh,
    output logic [3:0]  o_idx,
    output logic        o_busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GNT  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    state_e           state_q, state_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [3:0]       idx_q, idx_d;
    logic [15:0]      grant_q, grant_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [4:0]       pick_idle_s;
    logic [4:0]       pick_rel_s;
    logic             in_gnt_s;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back.
    // Result: {found, winner_index}.
    function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr);
        logic [31:0] dbl;
        logic [15:0] rot;
        logic [3:0]  k;
        dbl = {req, req} >> ptr;
        rot = dbl[15:0];
        k   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            k = rot[i] ? 4'(i) : k;
        end
        return {|rot, k + ptr};
    endfunction

    assign in_gnt_s    = (state_q == ST_GNT);
    assign pick_idle_s = rr_pick(req_valid, ptr_q);
    assign pick_rel_s  = rr_pick(req_valid & ~grant_q, idx_q + 4'd1);

    assign o_valid     = in_gnt_s & req_valid[idx_q];
    assign req_ready   = in_gnt_s ? (grant_q & {16{o_ready}}) : 16'h0000;
    assign o_busy      = in_gnt_s;
    assign o_grant_oh  = grant_q;
    assign o_idx       = idx_q;

    // Next-state: initial grant from IDLE, burst hold / release with re-arbitration, abort.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_idle_s[4]) begin
                    state_d = ST_GNT;
                    idx_d   = pick_idle_s[3:0];
                    grant_d = 16'd1 << pick_idle_s[3:0];
                    beat_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT: begin
                if (!o_valid) begin
                    // Requester withdrew before acceptance: drop grant, keep ptr.
                    state_d = ST_IDLE;
                    idx_d   = 4'd0;
                    grant_d = 16'h0000;
                    beat_d  = '0;
                end else if (o_ready) begin
                    if (req_lock[idx_q] && (beat_q < BURST_LAST)) begin
                        beat_d = beat_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        ptr_d = idx_q + 4'd1;
                        if (pick_rel_s[4]) begin
                            idx_d   = pick_rel_s[3:0];
                            grant_d = 16'd1 << pick_rel_s[3:0];
                            beat_d  = '0;
                        end else if (req_valid[idx_q]) begin
                            beat_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                            idx_d   = 4'd0;
                            grant_d = 16'h0000;
                            beat_d  = '0;
                        end
                    end
                end else begin
                    state_d = ST_GNT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = 4'd0;
                idx_d   = 4'd0;
                grant_d = 16'h0000;
                beat_d  = '0;
            end
        endcase
    end

    // State, pointer, grant and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 4'd0;
            idx_q   <= 4'd0;
            grant_q <= 16'h0000;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
        end
    end

endmodule
